id_ex_stage: RTL
================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter CTRL_W, default 8, width of the opaque control bundle carried to execute.
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports in_valid  input  1 and in_ready  output  1  decode-side handshake.
REQ-006 SHALL have ports in_pc, in_imm  input  32 each  decoded PC and immediate.
REQ-007 SHALL have ports in_rs1, in_rs2, in_rd  input  5 each  register indices.
REQ-008 SHALL have ports in_use_rs1, in_use_rs2, in_is_load  input  1 each  operand-use and load flags.
REQ-009 SHALL have port in_ctrl  input  CTRL_W  control bundle.
REQ-010 SHALL have ports rf_rdata1, rf_rdata2  input  32 each  asynchronous register-file read data for in_rs1/in_rs2.
REQ-011 SHALL have ports wb_en  input  1, wb_rd  input  5, wb_data  input  32  same write-back transaction driven into the register file.
REQ-012 SHALL have port flush  input  1  synchronous kill from branch resolution.
REQ-013 SHALL have ports out_valid  output  1 and out_ready  input  1  execute-side handshake.
REQ-014 SHALL have ports out_pc, out_imm, out_op1, out_op2  output  32 each; out_rs1, out_rs2, out_rd  output  5 each; out_is_load  output  1; out_ctrl  output  CTRL_W.
REQ-015 SHALL have port stall_cnt  output  CNT_W  saturating count of hazard-stall cycles.

Function
REQ-016 Output register SHALL be one entry; "advance" = !out_valid || out_ready.
REQ-017 hazard SHALL be 1 when out_valid && out_is_load && out_rd!=0 && in_valid && ((in_use_rs1 && in_rs1==out_rd) || (in_use_rs2 && in_rs2==out_rd)).
REQ-018 in_ready SHALL equal flush || (advance && !hazard), combinationally.
REQ-019 Write-through bypass: captured op1 SHALL be wb_data when wb_en && wb_rd!=0 && wb_rd==in_rs1, else rf_rdata1; op2 likewise with in_rs2; index 0 never bypassed.
REQ-020 On edge with flush=1: out_valid<=0, input discarded; flush has priority over all other actions.
REQ-021 On edge with advance && in_valid && !hazard && !flush: all out_* fields load from inputs (operands per REQ-019), out_valid<=1; latency one cycle.
REQ-022 On edge with advance && hazard && !flush: out_valid<=0 (bubble), payload fields may hold; decode instruction stays pending.
REQ-023 On edge with advance && !in_valid && !flush: out_valid<=0.
REQ-024 Hold (out_valid && !out_ready && !flush): all fields hold except held-operand refresh: out_op1<=wb_data when wb_en && wb_rd!=0 && wb_rd==out_rs1; out_op2 likewise.
REQ-025 Payload SHALL never change while out_valid && !out_ready except per REQ-024.
REQ-026 stall_cnt SHALL increment by 1 each edge where in_valid && !in_ready && !flush, saturating at all-ones (no wrap).
REQ-027 out_valid=0 payload values are don't-care for consumers but SHALL be deterministic (no X after reset).

Reset
REQ-028 rst=1 SHALL immediately, without clock, force out_valid=0, all out_* data fields=0, stall_cnt=0.
REQ-029 Reset asserted mid-transfer SHALL drop the in-flight entry; first capture possible on first rising edge after rst deasserts.
REQ-030 in_ready during reset SHALL be 1 (advance true, no hazard since out_valid=0).

Verification
REQ-031 Basic: rf_rdata1=0x11, rf_rdata2=0x22, in_valid=1, out_ready=1 -> next cycle out_valid=1, out_op1=0x11, out_op2=0x22, fields match inputs.
REQ-032 Bypass: in_rs1=5, rf_rdata1=0xAAAA, wb_en=1, wb_rd=5, wb_data=0x1234 -> out_op1=0x1234; repeat with wb_rd=0, in_rs1=0 -> out_op1=rf_rdata1.
REQ-033 Load-use: held out_is_load=1, out_rd=7; next in_rs2=7, in_use_rs2=1 -> in_ready=0 one cycle, bubble (out_valid=0), then instruction captured; stall_cnt=1.
REQ-034 Backpressure: out_ready=0 for 3 cycles with wb_en=1, wb_rd=out_rs1=3, wb_data=0xBEEF in cycle 2 -> out_op1=0xBEEF, other fields stable, in_ready=0 throughout.
REQ-035 Flush: flush=1 with out_valid=1, out_ready=0, hazard=1 -> in_ready=1, next cycle out_valid=0, stall_cnt unchanged.
REQ-036 Saturation and reset: force 2^CNT_W+5 hazard stalls -> stall_cnt=all-ones; assert rst between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// Decode-to-execute pipeline register: one entry with a valid/ready handshake
// on both sides. It reads operands from the register file, with a write-through
// bypass so that a write-back in the same cycle is seen. It detects load-use
// hazards against the held entry, and it refreshes held operands while
// execute applies backpressure. A saturating counter records hazard-stall
// cycles.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   in_valid / in_ready       decode-side handshake
//   in_pc, in_imm             decoded PC and immediate
//   in_rs1, in_rs2, in_rd     register indices
//   in_use_rs1, in_use_rs2    the instruction reads rs1 / rs2
//   in_is_load                the instruction is a load
//   in_ctrl                   opaque control bundle for execute
//   rf_rdata1, rf_rdata2      asynchronous register-file read data
//   wb_en, wb_rd, wb_data     write-back transaction going into the regfile
//   flush                     synchronous kill from branch resolution
//   out_valid / out_ready     execute-side handshake
//   out_*                     registered payload presented to execute
//   stall_cnt                 saturating count of stall cycles
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_pc,
    input  logic [31:0]       in_imm,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_use_rs1,
    input  logic              in_use_rs2,
    input  logic              in_is_load,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic [31:0]       wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [31:0]       out_imm,
    output logic [31:0]       out_op1,
    output logic [31:0]       out_op2,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic              out_is_load,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic advance;
    logic hazard;

    // Operand lanes as arrays so that both lanes share one bypass description.
    logic [4:0]  src_idx  [2];
    logic [31:0] rf_data  [2];
    logic [4:0]  held_idx [2];
    logic [31:0] held_op  [2];
    logic [31:0] cap_op   [2];
    logic [31:0] hold_op  [2];

    assign src_idx[0]  = in_rs1;
    assign src_idx[1]  = in_rs2;
    assign rf_data[0]  = rf_rdata1;
    assign rf_data[1]  = rf_rdata2;
    assign held_idx[0] = out_rs1;
    assign held_idx[1] = out_rs2;
    assign held_op[0]  = out_op1;
    assign held_op[1]  = out_op2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            // Regfile write and read in the same cycle: take the write data.
            // Index 0 is hard-wired zero and is never bypassed.
            assign cap_op[gi] = (wb_en && (wb_rd != 5'd0) && (wb_rd == src_idx[gi]))
                                ? wb_data : rf_data[gi];
            // While stalled by execute, a held operand may have been read
            // before its producer wrote back; pick up that write now.
            assign hold_op[gi] = (wb_en && (wb_rd != 5'd0) && (wb_rd == held_idx[gi]))
                                 ? wb_data : held_op[gi];
        end
    endgenerate

    assign advance = !out_valid || out_ready;

    // Load in the output register whose result a consumer in decode needs:
    // the load data is not available yet, so insert one bubble.
    assign hazard = out_valid && out_is_load && (out_rd != 5'd0) && in_valid &&
                    ((in_use_rs1 && (in_rs1 == out_rd)) ||
                     (in_use_rs2 && (in_rs2 == out_rd)));

    // A flush discards whatever decode offers, so it is always "accepted".
    assign in_ready = flush || (advance && !hazard);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_imm     <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_is_load <= 1'b0;
            out_ctrl    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            if (in_valid && !hazard) begin
                out_valid   <= 1'b1;
                out_pc      <= in_pc;
                out_imm     <= in_imm;
                out_op1     <= cap_op[0];
                out_op2     <= cap_op[1];
                out_rs1     <= in_rs1;
                out_rs2     <= in_rs2;
                out_rd      <= in_rd;
                out_is_load <= in_is_load;
                out_ctrl    <= in_ctrl;
            end else begin
                // Bubble (hazard) or nothing offered; payload holds.
                out_valid <= 1'b0;
            end
        end else begin
            // Held by execute: only operand refresh may change the payload.
            out_op1 <= hold_op[0];
            out_op2 <= hold_op[1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
